// File: rtl/uart_lcd_sched.sv
// Sequencer for the UART echo / LCD display datapath.
// It pops bytes from an RX FIFO, echoes them into a TX FIFO, and writes them
// into a 2x16 LCD character buffer, handling CR, BS and FF.
// Ports:
//   clk_50MHz, reset             - clock, synchronous active-high reset
//   rx_empty, rx_data, rx_rd     - RX FIFO read port (first-word-fall-through)
//   tx_full, tx_wr, tx_data      - TX FIFO write port
//   lcd_ready, lcd_we, lcd_addr,
//   lcd_char, lcd_refresh        - lcd1602 driver buffer/refresh port
//   cursor, busy, drop_count     - status
module uart_lcd_sched #(
  parameter bit         ECHO_EN    = 1'b1,
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter bit         REFRESH_EN = 1'b1
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_rd,
  input  logic       tx_full,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  input  logic       lcd_ready,
  output logic       lcd_we,
  output logic [4:0] lcd_addr,
  output logic [7:0] lcd_char,
  output logic       lcd_refresh,
  output logic [4:0] cursor,
  output logic       busy,
  output logic [7:0] drop_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_ECHO    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_CLEAR   = 3'd5;
  localparam logic [2:0] S_REFRESH = 3'd6;

  localparam logic [1:0] C_PRINT = 2'd0;
  localparam logic [1:0] C_CR    = 2'd1;
  localparam logic [1:0] C_BS    = 2'd2;
  localparam logic [1:0] C_FF    = 2'd3;

  localparam logic [4:0] LINE2_ADDR = 5'd16;
  localparam logic [4:0] LAST_ADDR  = 5'd31;
  localparam logic [7:0] DROP_MAX   = 8'hFF;

  logic [2:0] state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [1:0] cls_q, cls_d;
  logic [4:0] cursor_q, cursor_d;
  logic [7:0] drop_q, drop_d;
  logic       rx_rd_q, rx_rd_d;
  logic       tx_wr_q, tx_wr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       lcd_we_q, lcd_we_d;
  logic [4:0] lcd_addr_q, lcd_addr_d;
  logic [7:0] lcd_char_q, lcd_char_d;
  logic       lcd_refresh_q, lcd_refresh_d;
  logic       busy_q, busy_d;

  // Class-specific action, shared by the DECODE (no echo) and ECHO exits.
  logic       start_act;
  logic [1:0] act_cls;

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    cls_d         = cls_q;
    cursor_d      = cursor_q;
    drop_d        = drop_q;
    rx_rd_d       = 1'b0;
    tx_wr_d       = 1'b0;
    tx_data_d     = tx_data_q;
    lcd_we_d      = 1'b0;
    lcd_addr_d    = lcd_addr_q;
    lcd_char_d    = lcd_char_q;
    lcd_refresh_d = 1'b0;
    start_act     = 1'b0;
    act_cls       = cls_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_empty) begin
          rx_rd_d = 1'b1;
          byte_d  = rx_data;
          state_d = S_FETCH;
        end
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
          act_cls = C_PRINT;
        end else if (byte_q == 8'h0D) begin
          act_cls = C_CR;
        end else if (byte_q == 8'h08) begin
          act_cls = C_BS;
        end else if (byte_q == 8'h0C) begin
          act_cls = C_FF;
        end
        cls_d = act_cls;
        if (!(byte_q >= 8'h20 && byte_q <= 8'h7E) && byte_q != 8'h0D &&
            byte_q != 8'h08 && byte_q != 8'h0C) begin
          if (drop_q != DROP_MAX) drop_d = drop_q + 8'd1;
          state_d = S_IDLE;
        end else if (ECHO_EN) begin
          state_d = S_ECHO;
        end else begin
          start_act = 1'b1;
        end
      end

      S_ECHO: begin
        if (!tx_full) begin
          tx_wr_d   = 1'b1;
          tx_data_d = byte_q;
          start_act = 1'b1;
        end
      end

      // Hold the write strobe until the driver accepts it.
      S_WRITE: begin
        if (lcd_ready) begin
          if (cls_q == C_PRINT) cursor_d = cursor_q + 5'd1;
          state_d = S_REFRESH;
        end else begin
          lcd_we_d = 1'b1;
        end
      end

      // Walk addresses 0..31, advancing only on accepted writes.
      S_CLEAR: begin
        if (lcd_ready) begin
          if (lcd_addr_q == LAST_ADDR) begin
            cursor_d = 5'd0;
            state_d  = S_REFRESH;
          end else begin
            lcd_we_d   = 1'b1;
            lcd_addr_d = lcd_addr_q + 5'd1;
          end
        end else begin
          lcd_we_d = 1'b1;
        end
      end

      // Raise refresh for one cycle once the driver is ready, then leave.
      S_REFRESH: begin
        if (!REFRESH_EN || lcd_refresh_q) begin
          state_d = S_IDLE;
        end else if (lcd_ready) begin
          lcd_refresh_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (start_act) begin
      case (act_cls)
        C_PRINT: begin
          lcd_we_d   = 1'b1;
          lcd_addr_d = cursor_q;
          lcd_char_d = byte_q;
          state_d    = S_WRITE;
        end
        C_CR: begin
          cursor_d = (cursor_q < LINE2_ADDR) ? LINE2_ADDR : 5'd0;
          state_d  = S_REFRESH;
        end
        C_BS: begin
          if (cursor_q == 5'd0) begin
            state_d = S_REFRESH;
          end else begin
            cursor_d   = cursor_q - 5'd1;
            lcd_we_d   = 1'b1;
            lcd_addr_d = cursor_q - 5'd1;
            lcd_char_d = CLEAR_CHAR;
            state_d    = S_WRITE;
          end
        end
        default: begin
          lcd_we_d   = 1'b1;
          lcd_addr_d = 5'd0;
          lcd_char_d = CLEAR_CHAR;
          state_d    = S_CLEAR;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q       <= S_IDLE;
      byte_q        <= 8'h00;
      cls_q         <= C_PRINT;
      cursor_q      <= 5'd0;
      drop_q        <= 8'h00;
      rx_rd_q       <= 1'b0;
      tx_wr_q       <= 1'b0;
      tx_data_q     <= 8'h00;
      lcd_we_q      <= 1'b0;
      lcd_addr_q    <= 5'd0;
      lcd_char_q    <= 8'h00;
      lcd_refresh_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      cls_q         <= cls_d;
      cursor_q      <= cursor_d;
      drop_q        <= drop_d;
      rx_rd_q       <= rx_rd_d;
      tx_wr_q       <= tx_wr_d;
      tx_data_q     <= tx_data_d;
      lcd_we_q      <= lcd_we_d;
      lcd_addr_q    <= lcd_addr_d;
      lcd_char_q    <= lcd_char_d;
      lcd_refresh_q <= lcd_refresh_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_rd       = rx_rd_q;
  assign tx_wr       = tx_wr_q;
  assign tx_data     = tx_data_q;
  assign lcd_we      = lcd_we_q;
  assign lcd_addr    = lcd_addr_q;
  assign lcd_char    = lcd_char_q;
  assign lcd_refresh = lcd_refresh_q;
  assign cursor      = cursor_q;
  assign busy        = busy_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_uart_lcd_sched.sv
// Self-checking bench for uart_lcd_sched: table of single-byte transactions
// plus hand sequences for cursor wrap, stalls, reset abort and saturation.
module tb_uart_lcd_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rd;
  logic       tx_full = 1'b0;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       lcd_ready = 1'b1;
  logic       lcd_we;
  logic [4:0] lcd_addr;
  logic [7:0] lcd_char;
  logic       lcd_refresh;
  logic [4:0] cursor;
  logic       busy;
  logic [7:0] drop_count;

  uart_lcd_sched dut (
    .clk_50MHz  (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .rx_data    (rx_data),
    .rx_rd      (rx_rd),
    .tx_full    (tx_full),
    .tx_wr      (tx_wr),
    .tx_data    (tx_data),
    .lcd_ready  (lcd_ready),
    .lcd_we     (lcd_we),
    .lcd_addr   (lcd_addr),
    .lcd_char   (lcd_char),
    .lcd_refresh(lcd_refresh),
    .cursor     (cursor),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #10 clk = ~clk;

  // RX FIFO model and output logs, owned by this block only.
  logic [7:0] rxq[$];
  logic [7:0] txlog[$];
  logic [4:0] wa[$];
  logic [7:0] wc[$];
  logic [7:0] push_byte = 8'h00;
  int         push_seq = 0;
  int         push_seen = 0;
  int         ref_cnt = 0;
  int         txfull_err = 0;
  int         excl_err = 0;
  int         hold_err = 0;
  logic       hold_pend = 1'b0;
  logic [4:0] hold_addr = 5'd0;
  logic [7:0] hold_char = 8'h00;

  always @(negedge clk) begin
    if (push_seq != push_seen) begin
      rxq.push_back(push_byte);
      push_seen <= push_seq;
    end
    if (rx_rd && rxq.size() > 0) void'(rxq.pop_front());
    rx_empty <= (rxq.size() == 0);
    rx_data  <= (rxq.size() == 0) ? 8'h00 : rxq[0];
    if (tx_wr) begin
      txlog.push_back(tx_data);
      if (tx_full) txfull_err <= txfull_err + 1;
    end
    if (lcd_we && lcd_ready) begin
      wa.push_back(lcd_addr);
      wc.push_back(lcd_char);
    end
    if (lcd_refresh) ref_cnt <= ref_cnt + 1;
    if (lcd_we && lcd_refresh) excl_err <= excl_err + 1;
    if (hold_pend && !(lcd_we && lcd_addr == hold_addr && lcd_char == hold_char))
      hold_err <= hold_err + 1;
    hold_pend <= lcd_we && !lcd_ready && !reset;
    hold_addr <= lcd_addr;
    hold_char <= lcd_char;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    push_byte = b;
    push_seq  = push_seq + 1;
  endtask

  // Wait for the block to pick up a byte and return to IDLE.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    if (!busy) chk({name, "_start_timeout"}, 32'd1, 32'd0);
    n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    if (busy) chk({name, "_done_timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_wait(input logic [7:0] b);
    send(b);
    wait_done("send");
  endtask

  typedef struct {
    logic [7:0] din;
    int         n_tx;
    int         n_wr;
    logic [4:0] wr_addr;
    logic [7:0] wr_char;
    logic [4:0] cur;
    logic [7:0] drop;
    int         n_ref;
  } vec_t;

  vec_t vt[13];
  int   tb0, wb0, rb0, cnt;

  initial begin
    vt[0]  = '{8'h31, 1, 1,  5'd0,  8'h31, 5'd1,  8'd0, 1};
    vt[1]  = '{8'h32, 1, 1,  5'd1,  8'h32, 5'd2,  8'd0, 1};
    vt[2]  = '{8'h33, 1, 1,  5'd2,  8'h33, 5'd3,  8'd0, 1};
    vt[3]  = '{8'h0D, 1, 0,  5'd0,  8'h00, 5'd16, 8'd0, 1};
    vt[4]  = '{8'h0D, 1, 0,  5'd0,  8'h00, 5'd0,  8'd0, 1};
    vt[5]  = '{8'h08, 1, 0,  5'd0,  8'h00, 5'd0,  8'd0, 1};
    vt[6]  = '{8'h0C, 1, 32, 5'd0,  8'h20, 5'd0,  8'd0, 1};
    vt[7]  = '{8'h07, 0, 0,  5'd0,  8'h00, 5'd0,  8'd1, 0};
    vt[8]  = '{8'h7F, 0, 0,  5'd0,  8'h00, 5'd0,  8'd2, 0};
    vt[9]  = '{8'h7E, 1, 1,  5'd0,  8'h7E, 5'd1,  8'd2, 1};
    vt[10] = '{8'h20, 1, 1,  5'd1,  8'h20, 5'd2,  8'd2, 1};
    vt[11] = '{8'h08, 1, 1,  5'd1,  8'h20, 5'd1,  8'd2, 1};
    vt[12] = '{8'h1F, 0, 0,  5'd0,  8'h00, 5'd1,  8'd3, 0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cursor", 32'(cursor), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_strobes", {28'd0, rx_rd, tx_wr, lcd_we, lcd_refresh}, 32'd0);

    // Table of single-byte transactions.
    for (int i = 0; i < 13; i++) begin
      tb0 = txlog.size(); wb0 = wa.size(); rb0 = ref_cnt;
      send(vt[i].din);
      wait_done($sformatf("v%0d", i));
      chk($sformatf("v%0d_ntx", i), 32'(txlog.size() - tb0), 32'(vt[i].n_tx));
      if (vt[i].n_tx > 0 && txlog.size() > tb0)
        chk($sformatf("v%0d_txdata", i), 32'(txlog[tb0]), 32'(vt[i].din));
      chk($sformatf("v%0d_nwr", i), 32'(wa.size() - wb0), 32'(vt[i].n_wr));
      if (vt[i].n_wr > 0 && wa.size() > wb0) begin
        chk($sformatf("v%0d_wraddr", i), 32'(wa[wb0]), 32'(vt[i].wr_addr));
        chk($sformatf("v%0d_wrchar", i), 32'(wc[wb0]), 32'(vt[i].wr_char));
      end
      if (vt[i].din == 8'h0C && wa.size() >= wb0 + 32) begin
        cnt = 0;
        for (int k = 0; k < 32; k++)
          if (wa[wb0 + k] != 5'(k) || wc[wb0 + k] != 8'h20) cnt++;
        chk($sformatf("v%0d_clear_seq", i), 32'(cnt), 32'd0);
      end
      chk($sformatf("v%0d_cursor", i), 32'(cursor), 32'(vt[i].cur));
      chk($sformatf("v%0d_drop", i), 32'(drop_count), 32'(vt[i].drop));
      chk($sformatf("v%0d_nref", i), 32'(ref_cnt - rb0), 32'(vt[i].n_ref));
    end

    // Cursor 1 -> 15, then 'A' at 15 and CR from line 2.
    for (int i = 0; i < 14; i++) send_wait(8'h61);
    chk("pre15_cursor", 32'(cursor), 32'd15);
    wb0 = wa.size();
    send_wait(8'h41);
    chk("a15_addr", 32'(wa[wb0]), 32'd15);
    chk("a15_char", 32'(wc[wb0]), 32'h41);
    chk("a15_cursor", 32'(cursor), 32'd16);
    wb0 = wa.size();
    send_wait(8'h0D);
    chk("cr16_cursor", 32'(cursor), 32'd0);
    chk("cr16_nwr", 32'(wa.size() - wb0), 32'd0);

    // Cursor to 31 and wrap.
    send_wait(8'h0D);
    for (int i = 0; i < 15; i++) send_wait(8'h62);
    chk("pre31_cursor", 32'(cursor), 32'd31);
    wb0 = wa.size();
    send_wait(8'h5A);
    chk("z31_addr", 32'(wa[wb0]), 32'd31);
    chk("z31_char", 32'(wc[wb0]), 32'h5A);
    chk("z31_cursor", 32'(cursor), 32'd0);

    // Stall both TX FIFO and LCD driver.
    tb0 = txlog.size(); wb0 = wa.size(); rb0 = ref_cnt;
    @(posedge clk); #1 tx_full = 1'b1; lcd_ready = 1'b0;
    send(8'h42);
    repeat (50) @(negedge clk);
    chk("stall_tx_none", 32'(txlog.size() - tb0), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 tx_full = 1'b0;
    cnt = 0;
    while (!lcd_we && cnt < 10) begin @(negedge clk); cnt++; end
    chk("stall_we_seen", 32'(lcd_we), 32'd1);
    repeat (20) @(negedge clk);
    chk("stall_we_held", 32'(lcd_we), 32'd1);
    chk("stall_wr_none", 32'(wa.size() - wb0), 32'd0);
    @(posedge clk); #1 lcd_ready = 1'b1;
    wait_done("stall");
    chk("stall_ntx", 32'(txlog.size() - tb0), 32'd1);
    chk("stall_txdata", 32'(txlog[tb0]), 32'h42);
    chk("stall_nwr", 32'(wa.size() - wb0), 32'd1);
    chk("stall_wraddr", 32'(wa[wb0]), 32'd0);
    chk("stall_wrchar", 32'(wc[wb0]), 32'h42);
    chk("stall_cursor", 32'(cursor), 32'd1);
    chk("stall_nref", 32'(ref_cnt - rb0), 32'd1);
    chk("hold_err", 32'(hold_err), 32'd0);
    chk("txfull_err", 32'(txfull_err), 32'd0);
    chk("excl_err", 32'(excl_err), 32'd0);

    // Reset in the middle of CLEAR.
    send(8'h0C);
    cnt = 0;
    while (!(lcd_we && lcd_addr == 5'd10) && cnt < 100) begin @(negedge clk); cnt++; end
    chk("clr_reached_10", 32'(lcd_addr), 32'd10);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobes", {28'd0, rx_rd, tx_wr, lcd_we, lcd_refresh}, 32'd0);
    chk("mid_rst_cursor", 32'(cursor), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_addr", 32'(lcd_addr), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {30'd0, busy, lcd_we}, 32'd0);

    // Drop counter saturation.
    for (int i = 0; i < 256; i++) send_wait(8'h00);
    chk("drop_sat", 32'(drop_count), 32'd255);

    wb0 = wa.size();
    send_wait(8'h31);
    chk("final_addr", 32'(wa[wb0]), 32'd0);
    chk("final_cursor", 32'(cursor), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_lcd_sched.md
Name: uart_lcd_sched

Overview:
Controller that sequences the UART echo / LCD display datapath. Drains received bytes from the RX FIFO, echoes them into the TX FIFO and writes them into a 2x16 LCD character buffer. Manages cursor position and the control characters CR, BS and FF, then triggers an LCD refresh. Sits between the RX FIFO read port, the TX FIFO write port and the lcd1602 driver's character-buffer port.

Parameters:
ECHO_EN, 1, 1 = echo every accepted byte to TX FIFO; 0 = no TX writes.
CLEAR_CHAR, 8'h20, fill character for clear and backspace.
REFRESH_EN, 1, 1 = pulse lcd_refresh after each processed byte.

Ports:
clk_50MHz  in  1  system clock.
reset  in  1  synchronous, active-high reset.
rx_empty  in  1  RX FIFO empty.
rx_data  in  8  RX FIFO head byte (first-word-fall-through, valid when !rx_empty).
rx_rd  out  1  RX FIFO pop strobe, 1 cycle.
tx_full  in  1  TX FIFO full.
tx_wr  out  1  TX FIFO push strobe, 1 cycle.
tx_data  out  8  byte to push.
lcd_ready  in  1  LCD driver accepts a buffer write or refresh this cycle.
lcd_we  out  1  character-buffer write strobe.
lcd_addr  out  5  buffer address: 0-15 line 1, 16-31 line 2.
lcd_char  out  8  character to write.
lcd_refresh  out  1  1-cycle request to redraw the display.
cursor  out  5  current cursor position.
busy  out  1  high in any state except IDLE.
drop_count  out  8  count of discarded bytes, saturates at 255.

Behaviour:
- Reset, checked every clock edge with priority over all else:
  - State goes to IDLE.
  - cursor = 0, drop_count = 0.
  - All strobes = 0; tx_data, lcd_addr, lcd_char = 0; busy = 0.
  - Reset mid-operation aborts with no partial pulse after the edge.
- States: IDLE, FETCH, DECODE, ECHO, WRITE, CLEAR, REFRESH.
- IDLE:
  - If !rx_empty: rx_rd = 1 for one cycle, latch rx_data into byte register, go to FETCH.
  - Latency from rx_empty falling to rx_rd is 1 cycle.
- FETCH: one wait cycle for FIFO pointer update, then DECODE.
- DECODE classifies the latched byte:
  - 0x20-0x7E: printable.
  - 0x0D: CR.
  - 0x08: BS.
  - 0x0C: FF.
  - Anything else: drop_count += 1 (saturating), return to IDLE, no echo.
- ECHO (skipped if ECHO_EN = 0):
  - Hold until !tx_full, then tx_wr = 1 for exactly one cycle with tx_data = byte.
  - Never push while tx_full = 1.
  - Every accepted class is echoed verbatim.
- Action after ECHO, by class:
  - Printable: WRITE with lcd_addr = cursor, lcd_char = byte; then cursor += 1, wrapping 31 -> 0.
  - CR: no buffer write; cursor = 16 if cursor < 16, else 0.
  - BS:
    - If cursor = 0: no write, cursor stays 0.
    - Otherwise: cursor -= 1, then WRITE with CLEAR_CHAR at the new cursor; cursor does not advance after this write.
  - FF: enter CLEAR.
- WRITE: lcd_we asserted with lcd_addr and lcd_char stable until a cycle with lcd_ready = 1. The strobe is consumed in that cycle; the next cycle has lcd_we = 0.
- CLEAR:
  - 32 sequential writes of CLEAR_CHAR, addresses 0..31, each obeying the WRITE handshake.
  - Then cursor = 0.
- REFRESH:
  - Pulse lcd_refresh for one cycle when lcd_ready = 1, then go to IDLE.
  - If REFRESH_EN = 0, go straight to IDLE.
  - The CR path also passes through REFRESH.
- Strobe exclusivity: lcd_we and lcd_refresh are never high in the same cycle. rx_rd is asserted only in IDLE, so at most one byte is in flight.
- Bytes that arrive while busy wait in the RX FIFO; none are lost by this block.

Test Plan:
- Send 0x31, 0x32, 0x33 with tx_full = 0 and lcd_ready = 1 -> tx_wr pulses carry 31, 32, 33; lcd writes (0, 31), (1, 32), (2, 33); cursor = 3; three lcd_refresh pulses.
- Cursor at 15, send 0x41, then 0x0D -> 'A' written at addr 15, cursor = 16 after 'A'; CR moves cursor to 0.
- Cursor at 31, send 0x5A -> write at 31, cursor wraps to 0. Cursor at 0, send 0x08 -> echo 08, no lcd_we, cursor stays 0.
- Send 0x0C -> 32 writes of 0x20 to addrs 0..31, cursor = 0; one refresh pulse. Send 0x07 -> no echo, drop_count = 1.
- Hold tx_full = 1 for 50 cycles during ECHO, and lcd_ready = 0 for 20 cycles during WRITE -> no tx_wr while full; lcd_we held with stable addr and data; each strobe fires once on release.
- Assert reset during CLEAR at address 10 -> next cycle all strobes 0, cursor = 0, busy = 0, drop_count = 0.
